// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise operator: eight selectable two-operand ops with optional
// accumulator chaining, feeding a 2-entry valid/ready output buffer with flags.
module bitwise_logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc
);

    localparam int EW = WIDTH + 3;

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    tail_q, tail_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] res;
    logic [EW-1:0]    new_entry;
    logic             push;
    logic             pop;

    function automatic logic op_bit(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0:    op_bit = a & b;
            3'd1:    op_bit = ~(a & b);
            3'd2:    op_bit = a | b;
            3'd3:    op_bit = ~(a | b);
            3'd4:    op_bit = a ^ b;
            3'd5:    op_bit = ~(a ^ b);
            3'd6:    op_bit = ~a & b;
            default: op_bit = ~a | b;
        endcase
    endfunction

    // A clear arriving with a chained transfer must not feed the stale accumulator.
    assign op_a = in_chain ? (acc_clr ? '0 : acc_q) : in_a;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign res[gi] = op_bit(in_op, op_a[gi], in_b[gi]);
    end

    // Entry layout: {parity, ones, zero, result}
    assign new_entry = {^res, &res, ~|res, res};

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        acc_d   = acc_q;

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = new_entry;
                end else begin
                    tail_d = new_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            // Push with pop only happens at count 1, so the new entry replaces the head.
            2'b11: begin
                head_d = new_entry;
            end
            default: begin
            end
        endcase

        if (push) begin
            acc_d = res;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            acc_q   <= acc_d;
        end
    end

    assign out_result = head_q[WIDTH-1:0];
    assign out_zero   = head_q[WIDTH];
    assign out_ones   = head_q[WIDTH+1];
    assign out_parity = head_q[WIDTH+2];
    assign acc        = acc_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: vector table, corner sequences
// and a randomised stretch, all checked through an expected-result queue.
module tb_bitwise_logic_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_chain;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_ones;
    logic       out_parity;
    logic [7:0] acc;

    bitwise_logic_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_chain  (in_chain),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_parity(out_parity),
        .acc       (acc)
    );

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       ones;
        logic       par;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic [7:0] res;
        logic       zero;
        logic       ones;
        logic       par;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[11];
    int         total;
    int         bad;
    logic [7:0] model_acc;
    int         or_mode;
    logic       rnd_bit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: consumer stalls, 1: always ready, 2: random stalls
    assign out_ready = (or_mode == 1) || ((or_mode == 2) && rnd_bit);

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [7:0] calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    calc = a & b;
            3'd1:    calc = ~(a & b);
            3'd2:    calc = a | b;
            3'd3:    calc = ~(a | b);
            3'd4:    calc = a ^ b;
            3'd5:    calc = ~(a ^ b);
            3'd6:    calc = ~a & b;
            default: calc = ~a | b;
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] r);
        exp_t e;
        e.res  = r;
        e.zero = (r == 8'h00);
        e.ones = (r == 8'hFF);
        e.par  = ^r;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every popped head is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got result 0x%0h with nothing expected", out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_result !== e.res || out_zero !== e.zero ||
                    out_ones !== e.ones || out_parity !== e.par) begin
                    bad++;
                    $display("FAIL pop_result: got %h z%b o%b p%b expected %h z%b o%b p%b",
                             out_result, out_zero, out_ones, out_parity,
                             e.res, e.zero, e.ones, e.par);
                end else begin
                    $display("pop result=%h z=%b o=%b p=%b", out_result, out_zero, out_ones, out_parity);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chain, input logic clr, input exp_t e);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_chain = chain;
        acc_clr  = clr;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back(e);
                model_acc = e.res;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for op=%0d a=%h b=%h", op, a, b);
        end else begin
            $display("send op=%0d a=%h b=%h chain=%b clr=%b exp=%h", op, a, b, chain, clr, e.res);
        end
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [2:0] r_op;
        logic [7:0] r_a;
        logic [7:0] r_b;
        logic       r_ch;
        logic       r_clr;

        total     = 0;
        bad       = 0;
        model_acc = 8'h00;
        or_mode   = 1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_op     = 3'd0;
        in_chain  = 1'b0;
        acc_clr   = 1'b0;

        vecs[0]  = '{3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 8'h5A, 8'h0F, 1'b0, 8'hF5, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd3, 8'h5A, 8'h0F, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd7, 8'hA5, 8'h0F, 1'b0, 8'h5F, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'd4, 8'h00, 8'hFF, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'd5, 8'h00, 8'hFE, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd6, 8'h0F, 8'hFF, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 8'h77, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};

        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_acc", {24'd0, acc}, 32'd0);
        chk("rst_out_result", {24'd0, out_result}, 32'd0);
        chk("rst_flags", {29'd0, out_zero, out_ones, out_parity}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors, consumer always ready
        for (int i = 0; i < 11; i++) begin
            e.res  = vecs[i].res;
            e.zero = vecs[i].zero;
            e.ones = vecs[i].ones;
            e.par  = vecs[i].par;
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain, 1'b0, e);
            chk("vec_acc", {24'd0, acc}, {24'd0, vecs[i].res});
            chk("vec_latency", {31'd0, out_valid}, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: two accepted, third held off until the buffer drains
        or_mode = 0;
        send(3'd0, 8'hFF, 8'h12, 1'b0, 1'b0, mk_exp(8'h12));
        send(3'd2, 8'h40, 8'h03, 1'b0, 1'b0, mk_exp(8'h43));
        in_valid = 1'b1;
        in_op    = 3'd4;
        in_a     = 8'h0F;
        in_b     = 8'hF0;
        in_chain = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", {31'd0, in_ready}, 32'd0);
            chk("full_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_acc", {24'd0, acc}, 32'h43);
        end
        @(posedge clk);
        #1;
        or_mode = 1;
        @(negedge clk);
        chk("full_bubble_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        send(3'd4, 8'h0F, 8'hF0, 1'b0, 1'b0, mk_exp(8'hFF));
        chk("bp_third_acc", {24'd0, acc}, 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", sb.size(), 32'd0);

        // Clear coinciding with a chained transfer, then clear alone
        send(3'd2, 8'hAA, 8'h00, 1'b0, 1'b0, mk_exp(8'hAA));
        chk("clr_pre_acc", {24'd0, acc}, 32'hAA);
        send(3'd2, 8'h55, 8'h0C, 1'b1, 1'b1, mk_exp(8'h0C));
        chk("clr_chain_acc", {24'd0, acc}, 32'h0C);
        @(posedge clk);
        #1;
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        model_acc = 8'h00;
        chk("clr_alone_acc", {24'd0, acc}, 32'h00);

        // Asynchronous reset with two entries buffered
        or_mode = 0;
        send(3'd2, 8'h11, 8'h22, 1'b0, 1'b0, mk_exp(8'h33));
        send(3'd0, 8'hF0, 8'h70, 1'b0, 1'b0, mk_exp(8'h70));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_acc", {24'd0, acc}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        model_acc = 8'h00;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        or_mode = 1;
        send(3'd4, 8'h33, 8'h33, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b0});
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_acc", {24'd0, acc}, 32'd0);
        @(posedge clk);
        #1;

        // Random stretch with random consumer stalls
        or_mode = 2;
        for (int i = 0; i < 30; i++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_a   = 8'($urandom_range(0, 255));
            r_b   = 8'($urandom_range(0, 255));
            r_ch  = 1'($urandom_range(0, 1));
            r_clr = ($urandom_range(0, 4) == 0);
            e = mk_exp(calc(r_op, r_ch ? (r_clr ? 8'h00 : model_acc) : r_a, r_b));
            send(r_op, r_a, r_b, r_ch, r_clr, e);
            chk("rand_acc", {24'd0, acc}, {24'd0, model_acc});
        end
        or_mode = 1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("final_drained", sb.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
